// File: rtl/fp_pkg.sv
// Shared widths, saturation bounds and FSM encoding for the fixed-point MAC family.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Each operand gains one extension bit so signed and unsigned inputs share one signed multiplier.
  function automatic int prod_w(input int i1, input int f1, input int i2, input int f2);
    return (i1 + f1 + 1) + (i2 + f2 + 1);
  endfunction

  function automatic int acc_w(input int i1, input int f1, input int i2, input int f2,
                               input int guard);
    return i1 + i2 + 2 + guard + f1 + f2;
  endfunction

  function automatic logic [63:0] out_max(input int w, input logic is_signed);
    if (is_signed) return (64'd1 << (w - 1)) - 64'd1;
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] out_min(input int w, input logic is_signed);
    if (is_signed) return 64'd1 << (w - 1);
    return 64'd0;
  endfunction

endpackage

// File: rtl/fp_sat_quant.sv
// Re-quantises a wide accumulator to the output format: floor truncation, then
// clamping to the signed or unsigned output range.
module fp_sat_quant
  import fp_pkg::*;
#(
  parameter int ACC_W = 38,
  parameter int DROP  = 14,
  parameter int O_W   = 16
) (
  input  logic [ACC_W-1:0] acc,
  input  logic             is_signed,
  output logic [O_W-1:0]   c,
  output logic             overflow,
  output logic             underflow
);

  localparam int SH_W = ACC_W - DROP;
  localparam logic [63:0] S_MAX = out_max(O_W, 1'b1);
  localparam logic [63:0] S_MIN = out_min(O_W, 1'b1);
  localparam logic [63:0] U_MAX = out_max(O_W, 1'b0);
  localparam logic [63:0] U_MIN = out_min(O_W, 1'b0);

  // Dropping LSBs of a two's complement value is an arithmetic shift, i.e. floor.
  logic [SH_W-1:0] shifted;
  assign shifted = acc[ACC_W-1:DROP];

  generate
    if (DROP > 0) begin : g_drop
      assign underflow = |acc[DROP-1:0];
    end else begin : g_nodrop
      assign underflow = 1'b0;
    end
  endgenerate

  always_comb begin
    c        = shifted[O_W-1:0];
    overflow = 1'b0;
    if (is_signed) begin
      if (!(&shifted[SH_W-1:O_W-1] | ~|shifted[SH_W-1:O_W-1])) begin
        overflow = 1'b1;
        c        = shifted[SH_W-1] ? S_MIN[O_W-1:0] : S_MAX[O_W-1:0];
      end
    end else if (shifted[SH_W-1]) begin
      overflow = 1'b1;
      c        = U_MIN[O_W-1:0];
    end else if (|shifted[SH_W-2:O_W]) begin
      overflow = 1'b1;
      c        = U_MAX[O_W-1:0];
    end
  end

endmodule

// File: rtl/fp_mac.sv
// Pipelined fixed-point multiply-accumulate: operands -> product -> saturating
// accumulator, one re-quantised result per frame delivered over valid/ready.
module fp_mac
  import fp_pkg::*;
#(
  parameter int I1    = 2,
  parameter int F1    = 14,
  parameter int I2    = 2,
  parameter int F2    = 14,
  parameter int I3    = 2,
  parameter int F3    = 14,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [I1+F1-1:0] a,
  input  logic             s1,
  input  logic [I2+F2-1:0] b,
  input  logic             s2,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [I3+F3-1:0] c,
  output logic             sign,
  output logic             overflow,
  output logic             underflow
);

  localparam int A_W   = I1 + F1;
  localparam int B_W   = I2 + F2;
  localparam int P_W   = prod_w(I1, F1, I2, F2);
  localparam int ACC_W = acc_w(I1, F1, I2, F2, GUARD);
  localparam int DROP  = F1 + F2 - F3;
  localparam int O_W   = I3 + F3;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high; in_ready depends only on state/rst, and result fields hold while
  // out_valid is high until out_ready completes the transfer.
  state_t state_q, state_d;
  logic   accept, s3_done, out_fire;

  logic                  v1_q, v1_d, first1_q, first1_d, last1_q, last1_d, sgn1_q, sgn1_d;
  logic signed [A_W:0]   ax_q, ax_d;
  logic signed [B_W:0]   bx_q, bx_d;
  logic                  v2_q, v2_d, first2_q, first2_d, last2_q, last2_d, sgn2_q, sgn2_d;
  logic signed [P_W-1:0] prod_q, prod_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  acc_ovf_q, acc_ovf_d, fsign_q, fsign_d, in_frame_q, in_frame_d;
  logic [O_W-1:0]        c_q, c_d;
  logic                  sign_q, sign_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [ACC_W-1:0] pext, base;
  logic [ACC_W:0]   sum;
  logic             add_ovf;
  logic [O_W-1:0]   sq_c;
  logic             sq_ovf, sq_unf;

  assign accept   = in_valid & in_ready;
  assign s3_done  = v2_q & last2_q;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (s3_done) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready = !rst;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    v1_d       = accept;
    ax_d       = ax_q;
    bx_d       = bx_q;
    first1_d   = first1_q;
    last1_d    = last1_q;
    sgn1_d     = sgn1_q;
    in_frame_d = in_frame_q;
    if (accept) begin
      ax_d       = {s1 & a[A_W-1], a};
      bx_d       = {s2 & b[B_W-1], b};
      first1_d   = !in_frame_q;
      last1_d    = in_last;
      sgn1_d     = s1 | s2;
      in_frame_d = !in_last;
    end

    v2_d     = v1_q;
    prod_d   = prod_q;
    first2_d = first2_q;
    last2_d  = last2_q;
    sgn2_d   = sgn2_q;
    if (v1_q) begin
      prod_d   = P_W'(ax_q) * P_W'(bx_q);
      first2_d = first1_q;
      last2_d  = last1_q;
      sgn2_d   = sgn1_q;
    end
  end

  // The first beat of a frame starts from zero so no explicit clear is needed between frames.
  always_comb begin
    pext    = {{(ACC_W-P_W){prod_q[P_W-1]}}, prod_q};
    base    = first2_q ? '0 : acc_q;
    sum     = {base[ACC_W-1], base} + {pext[ACC_W-1], pext};
    add_ovf = sum[ACC_W] ^ sum[ACC_W-1];

    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    fsign_d   = fsign_q;
    if (v2_q) begin
      acc_d     = add_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
      acc_ovf_d = (first2_q ? 1'b0 : acc_ovf_q) | add_ovf;
      fsign_d   = (first2_q ? 1'b0 : fsign_q) | sgn2_q;
    end else if (out_fire) begin
      acc_d     = '0;
      acc_ovf_d = 1'b0;
      fsign_d   = 1'b0;
    end
  end

  fp_sat_quant #(
    .ACC_W (ACC_W),
    .DROP  (DROP),
    .O_W   (O_W)
  ) u_sat_quant (
    .acc       (acc_d),
    .is_signed (fsign_d),
    .c         (sq_c),
    .overflow  (sq_ovf),
    .underflow (sq_unf)
  );

  always_comb begin
    c_d    = c_q;
    sign_d = sign_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (s3_done) begin
      c_d    = sq_c;
      sign_d = fsign_d;
      ovf_d  = acc_ovf_d | sq_ovf;
      unf_d  = sq_unf;
    end else if (out_fire) begin
      c_d    = '0;
      sign_d = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      ax_q       <= '0;
      bx_q       <= '0;
      first1_q   <= 1'b0;
      last1_q    <= 1'b0;
      sgn1_q     <= 1'b0;
      in_frame_q <= 1'b0;
      v2_q       <= 1'b0;
      prod_q     <= '0;
      first2_q   <= 1'b0;
      last2_q    <= 1'b0;
      sgn2_q     <= 1'b0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      fsign_q    <= 1'b0;
      c_q        <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      ax_q       <= ax_d;
      bx_q       <= bx_d;
      first1_q   <= first1_d;
      last1_q    <= last1_d;
      sgn1_q     <= sgn1_d;
      in_frame_q <= in_frame_d;
      v2_q       <= v2_d;
      prod_q     <= prod_d;
      first2_q   <= first2_d;
      last2_q    <= last2_d;
      sgn2_q     <= sgn2_d;
      acc_q      <= acc_d;
      acc_ovf_q  <= acc_ovf_d;
      fsign_q    <= fsign_d;
      c_q        <= c_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign c         = c_q;
  assign sign      = sign_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_mac.sv
// Directed bench for fp_mac (Q2.14 operands and result) with hand-computed results.
module tb_fp_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic        s1 = 1'b0;
  logic [15:0] b = '0;
  logic        s2 = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] c;
  logic        sign;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .s1        (s1),
    .b         (b),
    .s2        (s2),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .sign      (sign),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one beat from a falling edge and holds it until accepted.
  task automatic send_beat(input logic [15:0] av, input logic sa, input logic [15:0] bv,
                           input logic sb, input logic last);
    int guard = 0;
    @(negedge clk);
    a = av; s1 = sa; b = bv; s2 = sb; in_last = last; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end else begin
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Waits for the frame result, checks it, optionally stalls, then completes the handshake.
  task automatic wait_result(input string tag, input logic [15:0] exp_c, input logic exp_sign,
                             input logic exp_ovf, input logic exp_unf, input int hold);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid && waited < 20);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (out_valid) begin
      check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd3);
      check({tag, "_c"}, 32'(c), 32'(exp_c));
      check({tag, "_sign"}, 32'(sign), 32'(exp_sign));
      check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
      check({tag, "_unf"}, 32'(underflow), 32'(exp_unf));
      if (hold > 0) begin
        a = 16'h7FFF; b = 16'h7FFF; in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
          check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
          check({tag, "_hold_c"}, 32'(c), 32'(exp_c));
          check({tag, "_hold_flags"}, {29'd0, sign, overflow, underflow},
                {29'd0, exp_sign, exp_ovf, exp_unf});
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_released"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int seen;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_flags", {29'd0, sign, overflow, underflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // 0.25 + 0.25 = 0.5
    send_beat(16'h2000, 1'b0, 16'h2000, 1'b0, 1'b0);
    send_beat(16'h1000, 1'b0, 16'h4000, 1'b0, 1'b1);
    wait_result("unsigned_sum", 16'h2000, 1'b0, 1'b0, 1'b0, 0);

    // -1.0 * 0.5 = -0.5
    send_beat(16'hC000, 1'b1, 16'h2000, 1'b0, 1'b1);
    wait_result("signed_neg", 16'hE000, 1'b1, 1'b0, 1'b0, 0);

    // 3 * 2.25 = 6.75, beyond the unsigned range; bubbles between beats
    send_beat(16'h6000, 1'b0, 16'h6000, 1'b0, 1'b0);
    idle(2);
    send_beat(16'h6000, 1'b0, 16'h6000, 1'b0, 1'b0);
    idle(1);
    send_beat(16'h6000, 1'b0, 16'h6000, 1'b0, 1'b1);
    wait_result("unsigned_sat", 16'hFFFF, 1'b0, 1'b1, 1'b0, 0);

    // -2.0 * 1.5 = -3.0, below the signed range
    send_beat(16'h8000, 1'b1, 16'h6000, 1'b0, 1'b1);
    wait_result("signed_sat", 16'h8000, 1'b1, 1'b1, 1'b0, 0);

    // 2^-28 truncates to zero
    send_beat(16'h0001, 1'b0, 16'h0001, 1'b0, 1'b1);
    wait_result("underflow", 16'h0000, 1'b0, 1'b0, 1'b1, 0);

    // Backpressure for 5 cycles, then the next frame must start from zero
    send_beat(16'hC000, 1'b1, 16'h2000, 1'b0, 1'b1);
    wait_result("backpressure", 16'hE000, 1'b1, 1'b0, 1'b0, 5);
    send_beat(16'h2000, 1'b0, 16'h4000, 1'b0, 1'b1);
    wait_result("after_hold", 16'h2000, 1'b0, 1'b0, 1'b0, 0);

    // Reset after two beats discards the frame
    send_beat(16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0);
    send_beat(16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    send_beat(16'h4000, 1'b0, 16'h4000, 1'b0, 1'b1);
    wait_result("post_rst_single", 16'h4000, 1'b0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
